cordic_rot_scheduler: RTL

//  Shares one pipelined rotation-mode CORDIC (sin/cos, 16 iterations) among NUM_REQ

---
 rtl/svd_cordic_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/cordic_rot_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/svd_cordic_pkg.sv
// Shared types and constants for the SVD array's CORDIC rotation scheduler.
package svd_cordic_pkg;

    localparam int CORDIC_LAT = 18;
    localparam int PHASE_W    = 32;
    localparam int SC_W       = 16;
    // Tag id is sized for the largest supported requester count (8).
    localparam int TAG_ID_W   = 3;
    localparam int CNT_W      = $clog2(CORDIC_LAT + 1);

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at rr_ptr+1, one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Scan requesters in rotating order and grant the first one found.
    always_comb begin
        int          idx_v;
        logic [ID_W-1:0] idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = int'(rr_ptr) + k;
            idx_v = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
            idx   = ID_W'(idx_v);
            if (advance && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cordic_rot_scheduler.sv
// Shares one pipelined rotation-mode CORDIC among NUM_REQ Jacobi rotation engines,
// tagging each issued phase so the returned sin/cos is routed back to its requester.
module cordic_rot_scheduler
    import svd_cordic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*PHASE_W-1:0] req_phase,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [SC_W-1:0]            rsp_sin,
    output logic [SC_W-1:0]            rsp_cos,
    output logic                       busy,
    output logic                       cordic_en,
    output logic [PHASE_W-1:0]         cordic_phase,
    input  logic [SC_W-1:0]            cordic_sin,
    input  logic [SC_W-1:0]            cordic_cos
);

    state_t             state_r, state_s;
    tag_t               tag_r [CORDIC_LAT];
    logic [CNT_W-1:0]   count_r, count_s;
    logic [ID_W-1:0]    rr_ptr_r, gid_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               grant_ok_s, hs_s, tail_s, rsp_ok_s, abort_s;

    // Reset is folded in so that every output reads zero while it is asserted.
    assign abort_s    = flush || (state_r == S_FLUSH);
    assign grant_ok_s = !rst && !abort_s;
    assign hs_s       = |grant_s;
    assign tail_s     = tag_r[CORDIC_LAT-1].vld;
    assign rsp_ok_s   = tail_s && !abort_s;
    assign req_ready  = grant_s;
    assign busy       = (count_r != CNT_W'(0));

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .advance (grant_ok_s),
        .rr_ptr  (rr_ptr_r),
        .grant   (grant_s)
    );

    // Encode the grant and steer the granted phase to the CORDIC.
    always_comb begin
        gid_s        = '0;
        cordic_phase = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                gid_s        = ID_W'(i);
                cordic_phase = req_phase[PHASE_W*i +: PHASE_W];
            end else begin
                gid_s        = gid_s;
            end
        end
    end

    // Response demux: the tail tag names the requester of the result on cordic_sin/cos.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rsp_ok_s && (tag_r[CORDIC_LAT-1].id == TAG_ID_W'(i));
        end
        rsp_sin = rsp_ok_s ? cordic_sin : '0;
        rsp_cos = rsp_ok_s ? cordic_cos : '0;
    end

    // In-flight count next value; issue and retire in one cycle cancel out.
    always_comb begin
        if (abort_s) begin
            count_s = '0;
        end else begin
            case ({hs_s, tail_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // FSM next state and CORDIC enable; enable only drops with work in flight on flush.
    always_comb begin
        state_s   = state_r;
        cordic_en = 1'b0;
        case (state_r)
            S_IDLE:  cordic_en = hs_s;
            S_RUN:   cordic_en = 1'b1;
            S_FLUSH: cordic_en = 1'b0;
            default: cordic_en = 1'b0;
        endcase
        if (flush) begin
            state_s = S_FLUSH;
        end else begin
            case (state_r)
                S_IDLE:  state_s = hs_s ? S_RUN : S_IDLE;
                S_RUN:   state_s = ((count_s == CNT_W'(0)) && !hs_s) ? S_IDLE : S_RUN;
                S_FLUSH: state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State, pointer, counter and tag pipe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            rr_ptr_r <= ID_W'(NUM_REQ - 1);
            count_r  <= '0;
            for (int i = 0; i < CORDIC_LAT; i++) tag_r[i] <= '0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            if (hs_s) rr_ptr_r <= gid_s;
            if (abort_s) begin
                for (int i = 0; i < CORDIC_LAT; i++) tag_r[i] <= '0;
            end else begin
                tag_r[0] <= '{vld: hs_s, id: TAG_ID_W'(gid_s)};
                for (int i = 1; i < CORDIC_LAT; i++) tag_r[i] <= tag_r[i-1];
            end
        end
    end

endmodule
